frame_streamer: RTL
===================

# frame_streamer

Parametrised multi-channel successor to the single-channel sample-to-UART controller. On a trigger it reads sample sets from the capture buffer and streams a framed packet to the UART transmitter: sync header, descriptor, enabled channels' samples (LS byte first) and an 8-bit checksum. A handshake timeout aborts stalled transfers. Sits between the trigger generator / capture buffer and uart_tx.

## Interface
- SAMPLE_WIDTH, 12: bits per channel sample, 1..16
- NUM_CH, 2: channels per sample set, 1..4
- TIMEOUT, 65535: max cycles waiting on i_sample_valid or i_tx_done, ≥2
- i_clk  in  1  system clock
- i_RESET_n  in  1  one clock; reset is asynchronous and active-low
- i_trigger_pulse  in  1  start-of-frame request (1-cycle pulse)
- i_ch_en  in  NUM_CH  channel enable mask, latched at trigger acceptance
- i_sample_valid  in  1  sample set valid (response to o_rd_en)
- i_sample_data  in  NUM_CH*SAMPLE_WIDTH  channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- i_capture_done  in  1  buffer holds no further sets
- i_tx_done  in  1  uart_tx finished current byte (1-cycle pulse)
- o_rd_en  out  1  1-cycle sample-set read request
- o_tx_data  out  8  byte to transmit
- o_tx_en  out  1  1-cycle transmit start
- o_transfer_done  out  1  1-cycle pulse, frame completed normally
- o_error  out  1  sticky timeout flag, cleared on next accepted trigger
- o_busy  out  1  frame in progress
- o_state  out  3  state encoding (debug)

## Operation
- States: IDLE=0, SEND=1, WAIT_TX=2, REQUEST=3, DONE=4, ABORT=5.
- Frame byte order: 0xA5; descriptor {SAMPLE_WIDTH-1 [3:0], mask zero-padded to 4 bits}; per set, enabled channels ascending, each BPS = ceil(SAMPLE_WIDTH/8) bytes, LS first, unused high bits 0; checksum.
- Checksum: sum mod 256 of descriptor and all data bytes (header excluded).
- IDLE: trigger accepted → latch mask, clear o_error, o_busy=1, SEND header. Triggers while o_busy=1 ignored.
- SEND: drive o_tx_data, pulse o_tx_en, → WAIT_TX, timeout counter cleared.
- WAIT_TX: on i_tx_done select next byte: header→descriptor; descriptor→REQUEST (or checksum if mask==0); data byte not last of set→next data byte; last of set→checksum if i_capture_done else REQUEST; checksum→DONE.
- REQUEST: o_rd_en pulsed on entry; on i_sample_valid latch whole i_sample_data, → SEND first data byte.
- DONE: o_transfer_done pulse, o_busy=0, → IDLE.
- Timeout: counter runs in WAIT_TX and REQUEST; reaching TIMEOUT without the awaited event → ABORT: o_error=1, o_busy=0, no o_transfer_done, → IDLE.
- Empty mask: frame is 0xA5, descriptor, checksum; no o_rd_en.
- i_capture_done is sampled only at the last-byte ack of a set; an initial request is always issued when mask≠0.

## Timing
- Reset (async, i_RESET_n=0): all outputs 0, o_state=IDLE, counters/latches cleared; effective immediately, including mid-frame. First edge after release runs normally.
- Trigger at cycle T → o_tx_en(0xA5) at T+2; o_busy high from T+1.
- i_tx_done at D → next o_tx_en at D+2, or o_rd_en at D+1.
- i_sample_valid at V → o_tx_en of first data byte at V+2.
- o_tx_data stable from o_tx_en until i_tx_done; o_tx_en never high twice without an intervening i_tx_done.
- i_tx_done outside WAIT_TX and i_sample_valid outside REQUEST ignored.
- Checksum ack at D → o_transfer_done at D+1, o_busy=0 at D+1; next trigger accepted from D+2.
- Timeout: o_error rises exactly TIMEOUT cycles after entering the waiting state.

## Test plan
- SAMPLE_WIDTH=12, NUM_CH=2, mask 2'b11, one set ch0=0x123, ch1=0xABC, capture_done=1 → bytes A5,B3,23,01,BC,0A,9D; one o_rd_en; one o_transfer_done.
- Same, mask 2'b10 → A5,B2,BC,0A,78; ch0 absent.
- Mask 2'b00 → A5,B0,B0; no o_rd_en; o_transfer_done pulse.
- Three sets, capture_done high only at third → 3 o_rd_en pulses, 2+3×4 data+header/descriptor bytes +checksum=15 bytes, correct sum; trigger during frame ignored.
- TIMEOUT=16, withhold i_tx_done after descriptor → o_error=1 16 cycles after WAIT_TX entry, o_busy=0, no o_transfer_done; next trigger clears o_error.
- Assert i_RESET_n=0 mid-WAIT_TX asynchronously → all outputs 0 before next edge; after release, trigger yields fresh frame starting 0xA5.

Source files
------------

// File: rtl/frame_streamer_if.sv
// Handshake bundle between frame_streamer, the trigger/capture-buffer side and uart_tx.
// The master modport is the streamer's view; the slave modport is the environment's view.
interface frame_streamer_if #(
    parameter int unsigned SAMPLE_WIDTH = 12,
    parameter int unsigned NUM_CH       = 2
);
    logic                           i_trigger_pulse;
    logic [NUM_CH-1:0]              i_ch_en;
    logic                           i_sample_valid;
    logic [NUM_CH*SAMPLE_WIDTH-1:0] i_sample_data;
    logic                           i_capture_done;
    logic                           i_tx_done;
    logic                           o_rd_en;
    logic [7:0]                     o_tx_data;
    logic                           o_tx_en;
    logic                           o_transfer_done;
    logic                           o_error;
    logic                           o_busy;
    logic [2:0]                     o_state;

    modport master (
        input  i_trigger_pulse, i_ch_en, i_sample_valid, i_sample_data,
               i_capture_done, i_tx_done,
        output o_rd_en, o_tx_data, o_tx_en, o_transfer_done, o_error,
               o_busy, o_state
    );

    modport slave (
        output i_trigger_pulse, i_ch_en, i_sample_valid, i_sample_data,
               i_capture_done, i_tx_done,
        input  o_rd_en, o_tx_data, o_tx_en, o_transfer_done, o_error,
               o_busy, o_state
    );
endinterface

// File: rtl/frame_streamer.sv
// Streams a framed packet (0xA5, descriptor, enabled channel samples LS byte first,
// checksum) from the capture buffer to uart_tx, aborting on handshake timeout.
module frame_streamer #(
    parameter int unsigned SAMPLE_WIDTH = 12,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic             i_clk,
    input  logic             i_RESET_n,
    frame_streamer_if.master bus
);
    localparam int unsigned BPS    = (SAMPLE_WIDTH + 7) / 8;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BYTE_W = (BPS > 1) ? $clog2(BPS) : 1;
    localparam int unsigned TW     = $clog2(TIMEOUT + 1);
    localparam int unsigned DW     = NUM_CH * SAMPLE_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND    = 3'd1;
    localparam logic [2:0] S_WAIT_TX = 3'd2;
    localparam logic [2:0] S_REQUEST = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ABORT   = 3'd5;

    localparam logic [1:0] K_HDR  = 2'd0;
    localparam logic [1:0] K_DESC = 2'd1;
    localparam logic [1:0] K_DATA = 2'd2;
    localparam logic [1:0] K_CSUM = 2'd3;

    logic [2:0]              state;
    logic [1:0]              kind;
    logic [NUM_CH-1:0]       mask;
    logic [DW-1:0]           samples;
    logic [CH_W-1:0]         ch_idx;
    logic [BYTE_W-1:0]       byte_idx;
    logic [7:0]              csum;
    logic [TW-1:0]           tmo;

    logic [CH_W-1:0]         first_ch;
    logic                    first_ok;
    logic [CH_W-1:0]         next_ch;
    logic                    next_ok;
    logic [SAMPLE_WIDTH-1:0] cur_sample;
    logic [BPS*8-1:0]        cur_ext;
    logic [7:0]              data_byte;
    logic [7:0]              tx_byte;
    logic                    last_of_set;
    logic                    tmo_hit;

    // Lowest enabled channel, and the next enabled channel above the current one.
    always_comb begin
        first_ch = '0;
        first_ok = 1'b0;
        next_ch  = '0;
        next_ok  = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (mask[c] && !first_ok) begin
                first_ch = CH_W'(c);
                first_ok = 1'b1;
            end
            if (mask[c] && (c > 32'(ch_idx)) && !next_ok) begin
                next_ch = CH_W'(c);
                next_ok = 1'b1;
            end
        end
    end

    always_comb begin
        cur_sample = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == ch_idx)
                cur_sample = samples[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
        cur_ext   = (BPS*8)'(cur_sample);
        data_byte = '0;
        for (int unsigned b = 0; b < BPS; b++) begin
            if (BYTE_W'(b) == byte_idx)
                data_byte = cur_ext[b*8 +: 8];
        end
    end

    always_comb begin
        case (kind)
            K_HDR:   tx_byte = 8'hA5;
            K_DESC:  tx_byte = {4'(SAMPLE_WIDTH - 1), 4'(mask)};
            K_DATA:  tx_byte = data_byte;
            default: tx_byte = csum;
        endcase
    end

    assign last_of_set = (byte_idx == BYTE_W'(BPS - 1)) && !next_ok;
    assign tmo_hit     = (tmo == TW'(TIMEOUT - 1));
    assign bus.o_state = state;

    always_ff @(posedge i_clk or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state               <= S_IDLE;
            kind                <= K_HDR;
            mask                <= '0;
            samples             <= '0;
            ch_idx              <= '0;
            byte_idx            <= '0;
            csum                <= '0;
            tmo                 <= '0;
            bus.o_rd_en         <= 1'b0;
            bus.o_tx_data       <= '0;
            bus.o_tx_en         <= 1'b0;
            bus.o_transfer_done <= 1'b0;
            bus.o_error         <= 1'b0;
            bus.o_busy          <= 1'b0;
        end else begin
            bus.o_tx_en         <= 1'b0;
            bus.o_rd_en         <= 1'b0;
            bus.o_transfer_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_trigger_pulse) begin
                        mask        <= bus.i_ch_en;
                        bus.o_error <= 1'b0;
                        bus.o_busy  <= 1'b1;
                        kind        <= K_HDR;
                        csum        <= '0;
                        state       <= S_SEND;
                    end
                end
                S_SEND: begin
                    bus.o_tx_data <= tx_byte;
                    bus.o_tx_en   <= 1'b1;
                    tmo           <= '0;
                    if (kind == K_DESC || kind == K_DATA)
                        csum <= csum + tx_byte;
                    state <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        case (kind)
                            K_HDR: begin
                                kind  <= K_DESC;
                                state <= S_SEND;
                            end
                            K_DESC: begin
                                if (mask == '0) begin
                                    kind  <= K_CSUM;
                                    state <= S_SEND;
                                end else begin
                                    bus.o_rd_en <= 1'b1;
                                    tmo         <= '0;
                                    state       <= S_REQUEST;
                                end
                            end
                            K_DATA: begin
                                if (!last_of_set) begin
                                    if (byte_idx != BYTE_W'(BPS - 1)) begin
                                        byte_idx <= byte_idx + 1'b1;
                                    end else begin
                                        byte_idx <= '0;
                                        ch_idx   <= next_ch;
                                    end
                                    state <= S_SEND;
                                end else if (bus.i_capture_done) begin
                                    kind  <= K_CSUM;
                                    state <= S_SEND;
                                end else begin
                                    bus.o_rd_en <= 1'b1;
                                    tmo         <= '0;
                                    state       <= S_REQUEST;
                                end
                            end
                            default: begin
                                bus.o_transfer_done <= 1'b1;
                                bus.o_busy          <= 1'b0;
                                state               <= S_DONE;
                            end
                        endcase
                    end else if (tmo_hit) begin
                        bus.o_error <= 1'b1;
                        bus.o_busy  <= 1'b0;
                        state       <= S_ABORT;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_REQUEST: begin
                    if (bus.i_sample_valid) begin
                        samples  <= bus.i_sample_data;
                        kind     <= K_DATA;
                        ch_idx   <= first_ch;
                        byte_idx <= '0;
                        state    <= S_SEND;
                    end else if (tmo_hit) begin
                        bus.o_error <= 1'b1;
                        bus.o_busy  <= 1'b0;
                        state       <= S_ABORT;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ABORT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
